// File: rtl/pipeline_chain_if.sv
// Handshake bundle for pipeline_chain: the stage-0 input side and the retiring output side.
// The master modport belongs to the producer/consumer; the pipeline itself takes the slave modport.
interface pipeline_chain_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_fire;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_fire
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_fire
  );
endinterface

// File: rtl/pipeline_chain.sv
// DEPTH-stage valid/data pipeline with global enable, partial stall with bubble insertion and per-stage flush.
// Define PIPELINE_CHAIN_PERF_EN to build the saturating stall/bubble counters; otherwise they read 0.
module pipeline_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             stall,
  input  logic [2:0]       stall_at,
  input  logic [DEPTH-1:0] flush,
  input  logic             perf_clr,
  output logic [DEPTH-1:0] stage_valid,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt,
  pipeline_chain_if.slave  bus
);

  localparam logic [2:0] LAST = 3'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 8) begin : g_depth_check
    $error("pipeline_chain: DEPTH must be in 2..8");
  end

  logic [2:0]       k;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_src;
  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] bubble;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] d_src [DEPTH];
  logic             last_held;

  // Stall boundaries beyond the last stage collapse onto it, freezing the whole chain.
  assign k = (stall_at > LAST) ? LAST : stall_at;

  always_comb begin
    v_src[0] = bus.in_valid;
    d_src[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      v_src[i] = v[i-1];
      d_src[i] = d[i-1];
    end
  end

  always_comb begin
    hold   = '0;
    bubble = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hold[i]   = ~en | (stall & (4'(i) <= {1'b0, k}));
      bubble[i] = en & stall & (4'(i) == ({1'b0, k} + 4'd1));
    end
  end

  // Flush wins over everything; the bubble stage still takes its source data, which is harmless with v=0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[i] || bubble[i]) begin
          v[i] <= 1'b0;
        end else if (!hold[i]) begin
          v[i] <= v_src[i];
        end
        if (!hold[i]) begin
          d[i] <= d_src[i];
        end
      end
    end
  end

  assign last_held     = stall & (k == LAST);
  assign bus.in_ready  = en & ~stall;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.out_fire  = en & v[DEPTH-1] & ~flush[DEPTH-1] & ~last_held;
  assign stage_valid   = v;

`ifdef PIPELINE_CHAIN_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (en && stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (en && !v[DEPTH-1] && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = perf_clr;
  assign stall_cnt   = '0;
  assign bubble_cnt  = '0;
`endif

endmodule
